// File: rtl/vec_exec_unit.sv
// Multi-cycle vector execution unit: NREGS x MAXLEN element register file, LANES elements per beat.
// Build option: define VEC_MUL_EN to enable op 101 (element-wise multiply, low WIDTH bits).
module vec_exec_unit #(
  parameter int WIDTH  = 32,
  parameter int LANES  = 4,
  parameter int MAXLEN = 16,
  parameter int NREGS  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2:0]                  op,
  input  logic [$clog2(NREGS)-1:0]    va,
  input  logic [$clog2(NREGS)-1:0]    vb,
  input  logic [$clog2(NREGS)-1:0]    vd,
  input  logic [$clog2(MAXLEN):0]     vlen,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  flags,
  input  logic                        wr_en,
  input  logic [$clog2(NREGS)-1:0]    wr_reg,
  input  logic [$clog2(MAXLEN)-1:0]   wr_idx,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic [$clog2(NREGS)-1:0]    rd_reg,
  input  logic [$clog2(MAXLEN)-1:0]   rd_idx,
  output logic [WIDTH-1:0]            rd_data
);

  localparam int RW  = $clog2(NREGS);
  localparam int IW  = $clog2(MAXLEN);
  localparam int LW  = IW + 1;
  localparam int LSH = $clog2(LANES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [RW-1:0]      va_q, vb_q, vd_q;
  logic [LW-1:0]      len_q;
  logic [LW-1:0]      beat_q;
  logic               n_q, z_q;
  logic [1:0]         flags_q;
  logic               busy_q, done_q;
  logic [WIDTH-1:0]   mem_q [NREGS][MAXLEN];

  logic [LW-1:0]      eff_len_s;
  logic [LW-1:0]      base_s;
  logic               last_s;
  logic               op_ok_s;
  logic               n_d, z_d;
  logic [LW-1:0]      lane_e_s [LANES];
  logic [WIDTH-1:0]   res_s [LANES];
  logic [LANES-1:0]   lane_wr_s;

  function automatic logic op_valid(input logic [2:0] o);
    logic ok;
    case (o)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b100: ok = 1'b1;
`ifdef VEC_MUL_EN
      3'b101: ok = 1'b1;
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [WIDTH-1:0] lane_op(input logic [2:0] o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (o)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = b;
`ifdef VEC_MUL_EN
      3'b101:  r = a * b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  assign busy    = busy_q;
  assign done    = done_q;
  assign flags   = flags_q;
  assign rd_data = mem_q[rd_reg][rd_idx];

  // Effective length clamp for an incoming request
  always_comb begin
    if (vlen > LW'(MAXLEN)) begin
      eff_len_s = LW'(MAXLEN);
    end else begin
      eff_len_s = vlen;
    end
  end

  // Per-lane element index, result, write enable and flag accumulation for the current beat
  always_comb begin
    base_s    = beat_q << LSH;
    last_s    = ((base_s + LW'(LANES)) >= len_q);
    op_ok_s   = op_valid(op_q);
    n_d       = n_q;
    z_d       = z_q;
    lane_wr_s = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_e_s[i] = base_s + LW'(i);
      res_s[i]    = lane_op(op_q, mem_q[va_q][lane_e_s[i][IW-1:0]],
                            mem_q[vb_q][lane_e_s[i][IW-1:0]]);
      if ((state_q == S_EXEC) && op_ok_s && (lane_e_s[i] < len_q)) begin
        lane_wr_s[i] = 1'b1;
        n_d = n_d | res_s[i][WIDTH-1];
        z_d = z_d & (res_s[i] == '0);
      end else begin
        lane_wr_s[i] = 1'b0;
      end
    end
  end

  // Control FSM with registered busy/done/flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      va_q    <= '0;
      vb_q    <= '0;
      vd_q    <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b1;
      flags_q <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            va_q   <= va;
            vb_q   <= vb;
            vd_q   <= vd;
            len_q  <= eff_len_s;
            beat_q <= '0;
            n_q    <= 1'b0;
            z_q    <= 1'b1;
            busy_q <= 1'b1;
            if (eff_len_s == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              flags_q <= 2'b01;
            end else begin
              state_q <= S_EXEC;
            end
          end else begin
            busy_q <= 1'b0;
          end
        end
        S_EXEC: begin
          n_q    <= n_d;
          z_q    <= z_d;
          beat_q <= beat_q + LW'(1);
          if (last_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            flags_q <= {n_d, z_d};
          end else begin
            done_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Element array: vector results while executing, scalar writes only when idle; never reset
  always_ff @(posedge clk) begin
    if (state_q == S_EXEC) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_wr_s[i]) begin
          mem_q[vd_q][lane_e_s[i][IW-1:0]] <= res_s[i];
        end
      end
    end else if ((state_q == S_IDLE) && wr_en) begin
      mem_q[wr_reg][wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Directed table-driven bench for vec_exec_unit at default parameters, plus
// hand sequences for aliasing, ignored start/write while busy, write+start, and mid-op reset.
module tb_vec_exec_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [3:0]  va, vb, vd;
  logic [4:0]  vlen;
  logic        busy, done;
  logic [1:0]  flags;
  logic        wr_en;
  logic [3:0]  wr_reg, wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  rd_reg, rd_idx;
  logic [31:0] rd_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] model [16][16];

  typedef struct {
    logic [2:0] op;
    int         va;
    int         vb;
    int         vd;
    int         vlen;
    int         lat;
    logic [1:0] flags;
  } vec_t;

  vec_t vecs [10];

  vec_exec_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .va(va), .vb(vb), .vd(vd),
    .vlen(vlen), .busy(busy), .done(done), .flags(flags), .wr_en(wr_en),
    .wr_reg(wr_reg), .wr_idx(wr_idx), .wr_data(wr_data), .rd_reg(rd_reg),
    .rd_idx(rd_idx), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic bit op_ok(input logic [2:0] o);
`ifdef VEC_MUL_EN
    return (o <= 3'd5);
`else
    return (o <= 3'd4);
`endif
  endfunction

  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    case (o)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return b;
      3'd5: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input int r, input int i, input logic [31:0] d);
    wr_en = 1'b1; wr_reg = 4'(r); wr_idx = 4'(i); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[r][i] = d;
  endtask

  task automatic chk_reg(input int r, input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_reg = 4'(r); rd_idx = 4'(i);
      #1;
      chk($sformatf("%s v%0d[%0d]", tag, r, i), rd_data, model[r][i]);
    end
    @(posedge clk); #1;
  endtask

  task automatic rd_chk(input string nm, input int r, input int i, input logic [31:0] exp);
    rd_reg = 4'(r); rd_idx = 4'(i);
    #1;
    chk(nm, rd_data, exp);
  endtask

  task automatic start_op;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int base, output int lat);
    lat = base;
    while (done !== 1'b1 && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic set_op(input logic [2:0] o, input int a, input int b, input int d, input int l);
    op = o; va = 4'(a); vb = 4'(b); vd = 4'(d); vlen = 5'(l);
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int lat;
    int eff;
    set_op(v.op, v.va, v.vb, v.vd, v.vlen);
    start_op();
    chk($sformatf("busy_after_start[%0d]", k), 32'(busy), 32'd1);
    wait_done(1, lat);
    chk($sformatf("latency[%0d]", k), 32'(lat), 32'(v.lat));
    chk($sformatf("flags[%0d]", k), 32'(flags), 32'(v.flags));
    @(posedge clk); #1;
    chk($sformatf("idle_busy[%0d]", k), 32'(busy), 32'd0);
    chk($sformatf("idle_done[%0d]", k), 32'(done), 32'd0);
    eff = (v.vlen > 16) ? 16 : v.vlen;
    if (op_ok(v.op)) begin
      for (int e = 0; e < eff; e++) begin
        model[v.vd][e] = ref_op(v.op, model[v.va][e], model[v.vb][e]);
      end
    end
    chk_reg(v.vd, $sformatf("vec%0d", k));
  endtask

  initial begin
    int lat;
    clk = 1'b0; reset = 1'b0; start = 1'b0; op = 3'd0; va = 4'd0; vb = 4'd0; vd = 4'd0;
    vlen = 5'd0; wr_en = 1'b0; wr_reg = 4'd0; wr_idx = 4'd0; wr_data = 32'd0;
    rd_reg = 4'd0; rd_idx = 4'd0;

    vecs[0] = '{3'd0, 1, 2, 3, 16, 5, 2'b00};
    vecs[1] = '{3'd1, 2, 2, 4, 6, 3, 2'b01};
    vecs[2] = '{3'd1, 1, 2, 5, 1, 2, 2'b10};
    vecs[3] = '{3'd1, 1, 2, 5, 0, 1, 2'b01};
    vecs[4] = '{3'd2, 1, 2, 8, 20, 5, 2'b00};
    vecs[5] = '{3'd3, 1, 4, 9, 8, 3, 2'b10};
    vecs[6] = '{3'd4, 0, 4, 10, 4, 2, 2'b01};
    vecs[7] = '{3'd6, 1, 2, 11, 16, 5, 2'b01};
    vecs[8] = '{3'd5, 7, 7, 12, 1, 2, 2'b01};
    vecs[9] = '{3'd0, 1, 2, 15, 4, 2, 2'b00};

    #2;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_flags", 32'(flags), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i < 16; i++) begin
        wr(r, i, 32'hC000_0000 | 32'(r * 256 + i));
      end
    end
    for (int i = 0; i < 16; i++) begin
      wr(1, i, 32'(i + 1));
      wr(2, i, 32'd10);
      wr(4, i, 32'hFFFF_FFFF);
    end
    wr(7, 0, 32'h0001_0000);

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k], k);
    end

    for (int i = 0; i < 16; i++) begin
      rd_chk($sformatf("add_v3[%0d]", i), 3, i, 32'(i + 11));
    end
    rd_chk("sub_v4_kept", 4, 6, 32'hFFFF_FFFF);
    rd_chk("sub_v4_zero", 4, 5, 32'd0);
    rd_chk("sub_v5_neg", 5, 0, 32'hFFFF_FFF7);
`ifdef VEC_MUL_EN
    rd_chk("mul_v12", 12, 0, 32'd0);
`else
    rd_chk("mul_v12_untouched", 12, 0, 32'hC000_0C00);
`endif
    @(posedge clk); #1;

    // aliasing v1 = v1 + v1 with a start and a scalar write pulsed mid-op
    set_op(3'd0, 1, 1, 1, 16);
    start_op();
    @(posedge clk); #1;
    set_op(3'd4, 0, 4, 3, 16);
    start = 1'b1; wr_en = 1'b1; wr_reg = 4'd3; wr_idx = 4'd0; wr_data = 32'h0000_0BAD;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    wait_done(3, lat);
    chk("alias_latency", 32'(lat), 32'd5);
    chk("alias_flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    chk("alias_idle_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("no_queued_busy", 32'(busy), 32'd0);
    chk("no_queued_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) begin
      model[1][i] = 32'(2 * (i + 1));
      rd_chk($sformatf("alias_v1[%0d]", i), 1, i, 32'(2 * (i + 1)));
    end
    @(posedge clk); #1;
    chk_reg(3, "busy_ignored");

    // scalar write and start in the same idle cycle: op sees the new value
    set_op(3'd0, 2, 2, 13, 1);
    wr_en = 1'b1; wr_reg = 4'd2; wr_idx = 4'd0; wr_data = 32'd5;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    model[2][0] = 32'd5;
    wait_done(1, lat);
    chk("wrstart_latency", 32'(lat), 32'd2);
    chk("wrstart_flags", 32'(flags), 32'd0);
    @(posedge clk); #1;
    model[13][0] = 32'd10;
    rd_chk("wrstart_v13", 13, 0, 32'd10);
    @(posedge clk); #1;
    chk_reg(13, "wrstart");

    // reset dropped during beat 2 of a 16-element op
    set_op(3'd0, 1, 2, 14, 16);
    start_op();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_flags", 32'(flags), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_no_done[%0d]", c), 32'(done), 32'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    for (int e = 0; e < 8; e++) begin
      model[14][e] = model[1][e] + model[2][e];
    end
    rd_chk("abort_v14_0", 14, 0, 32'd7);
    rd_chk("abort_v14_7", 14, 7, 32'd26);
    rd_chk("abort_v14_8", 14, 8, 32'hC000_0E08);
    @(posedge clk); #1;
    chk_reg(14, "abort");

    run_vec(vecs[9], 9);
    rd_chk("post_reset_v15", 15, 3, 32'd18);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_exec_unit.md
Name: vec_exec_unit

Overview:
- Multi-cycle vector execution unit; successor to the fixed 5-lane single-cycle vector path.
- Holds NREGS vector registers of MAXLEN elements and executes element-wise ops at LANES elements per cycle.
- Sequenced by a start/busy/done handshake from the core control unit.
- Scalar element write/read ports connect it to the memory/scalar datapath.

Parameters:
WIDTH, 32, element width in bits
LANES, 4, elements processed per cycle (power of two, 1..MAXLEN)
MAXLEN, 16, elements per vector register (multiple of LANES)
NREGS, 16, number of vector registers (index width 4 at default)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request op; accepted only in IDLE
op  input  3  000 ADD, 001 SUB(a-b), 010 AND, 011 ORR, 100 MOV(b), 101 MUL (optional), others reserved
va  input  log2(NREGS)  source A register
vb  input  log2(NREGS)  source B register
vd  input  log2(NREGS)  destination register
vlen  input  log2(MAXLEN)+1  element count for this op
busy  output  1  op in flight
done  output  1  one-cycle completion pulse
flags  output  2  {N,Z} of last completed op
wr_en  input  1  scalar element write
wr_reg  input  log2(NREGS)  element write register
wr_idx  input  log2(MAXLEN)  element write index
wr_data  input  WIDTH  element write data
rd_reg  input  log2(NREGS)  element read register
rd_idx  input  log2(MAXLEN)  element read index
rd_data  output  WIDTH  combinational read of rd_reg[rd_idx]

Behaviour:
- Reset (reset=0, async): state IDLE, busy=0, done=0, flags=2'b00, beat counter 0. Register-file contents are not cleared.
- States: IDLE -> EXEC -> DONE -> IDLE.
- IDLE:
  - start=1 latches op, va, vb, vd and effective length L = min(vlen, MAXLEN).
  - Clears accumulated N=0, Z=1.
  - Goes to EXEC, or directly to DONE if L=0.
- EXEC, beat k (0-based):
  - Each lane i computes element e = k*LANES+i; result written to vd[e] only if e < L.
  - Beat count is ceil(L/LANES); the last beat may be partial, and unused lanes write nothing.
  - Results truncate to WIDTH bits (wrap-around); no carry/overflow reporting.
  - N |= MSB of any written result; Z &= (result==0) for every written result.
  - After the last beat -> DONE.
- DONE: done=1 for exactly one cycle; flags updated to {N,Z}; then IDLE.
- Handshake and timing:
  - busy=1 in EXEC and DONE, 0 in IDLE.
  - Latency from start edge to done = ceil(L/LANES)+1 cycles.
  - flags hold until the next done.
- Aliasing: vd may equal va and/or vb. Each element is read and written in the same beat, so results equal the pre-op operand values.
- start while busy: ignored, no queuing.
- wr_en:
  - In IDLE, writes wr_reg[wr_idx] at the clock edge.
  - While busy, ignored (vector op owns the array).
  - If wr_en and an accepted start occur in the same IDLE cycle, the write lands first; the op sees the written value on its first beat.
- Reserved op: no element writes, flags result {0,1}, normal timing.
- rd_data is always valid combinationally. During EXEC it reflects already-written elements.
- Reset mid-operation: aborts immediately, no done pulse. Elements already written keep new values; the rest keep old values.

Optional Feature:
- Macro VEC_MUL_EN.
- Defined: op 101 = element-wise multiply, low WIDTH bits of a*b, same single-beat timing per LANES elements.
- Undefined: op 101 is reserved (no writes, flags {0,1}) and no multiplier is instantiated.

Test Plan:
- Defaults assumed (WIDTH=32, LANES=4, MAXLEN=16).
- Load v1[i]=i+1, v2[i]=10 via wr_en; ADD vd=3, vlen=16 -> done exactly 5 cycles after start; v3[i]=i+11; flags {0,0}.
- SUB v4=v2-v2 with vlen=6 -> 2 EXEC beats; v4[0..5]=0; v4[6..15] unchanged (preloaded 0xFFFFFFFF); flags {0,1}.
- SUB v5=v1-v2 with vlen=1, v1[0]=1 -> v5[0]=0xFFFFFFF7, flags {1,0}; vlen=0 -> done 1 cycle after start, no writes, flags {0,1}.
- Aliasing ADD v1=v1+v1 vlen=16 -> v1[i]=2*(i+1). Start and wr_en pulsed mid-op -> both ignored, array unchanged apart from the op.
- Drop reset to 0 during beat 2 of a 16-element op -> busy=0 immediately, no done; elements 0..7 new, 8..15 old. Next start runs normally.
- op 101 with a=0x10000, b=0x10000 -> VEC_MUL_EN defined: result 0, Z=1; undefined: destination untouched, flags {0,1}.
